// File: rtl/user_wr_reg.sv
// Write-side JTAG user data register: LSB-first serial shift-in with a shadowed parallel output and a commit strobe.
// Optional shift-length checking is enabled by defining USER_WR_LEN_CHK_EN.
module user_wr_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic             DRCK,
    input  logic             RST,
    input  logic             SEL,
    input  logic             FSH,
    input  logic             TDI,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    output logic             TDO,
    output logic [WIDTH-1:0] PO,
    output logic             UPD_STRB,
    output logic             LEN_ERR
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ARMED = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] po_q;
    logic             strb;
    logic             act;
    logic             do_cap;
    logic             do_shift;
    logic             do_upd;
    logic             len_ok;
    logic             commit;

    // CAPTURE outranks SHIFT, which outranks UPDATE; UPDATE only counts while ARMED.
    assign act      = SEL & FSH;
    assign do_cap   = act & CAPTURE;
    assign do_shift = act & ~CAPTURE & SHIFT;
    assign do_upd   = act & ~CAPTURE & ~SHIFT & UPDATE & (state == ARMED);
    assign commit   = do_upd & len_ok;

`ifdef USER_WR_LEN_CHK_EN
    localparam int            CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [CW-1:0] cnt;
    logic          len_err;

    // Saturating at WIDTH+1 keeps any over-length shift distinguishable from an exact one.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (do_cap) begin
            cnt <= '0;
        end else if (do_shift && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            len_err <= 1'b0;
        end else if (do_cap) begin
            len_err <= 1'b0;
        end else if (do_upd && !len_ok) begin
            len_err <= 1'b1;
        end
    end

    assign len_ok  = (cnt == CNT_FULL);
    assign LEN_ERR = len_err;
`else
    assign len_ok  = 1'b1;
    assign LEN_ERR = 1'b0;
`endif

    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else if (do_cap) begin
            state <= ARMED;
        end else if (do_upd) begin
            state <= IDLE;
        end
    end

    // Capture loads the committed word so it shifts back out for read-back.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            sr <= '0;
        end else if (do_cap) begin
            sr <= po_q;
        end else if (do_shift) begin
            sr <= {TDI, sr[WIDTH-1:1]};
        end
    end

    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            po_q <= DEFAULT;
        end else if (commit) begin
            po_q <= sr;
        end
    end

    // The strobe is a single-cycle pulse and drops even if the chain goes inactive.
    always_ff @(posedge DRCK or posedge RST) begin
        if (RST) begin
            strb <= 1'b0;
        end else begin
            strb <= commit;
        end
    end

    assign TDO      = act & sr[0];
    assign PO       = po_q;
    assign UPD_STRB = strb;

endmodule

// File: tb/tb_user_wr_reg.sv
// Bench for user_wr_reg (WIDTH=8, DEFAULT=8'hA5): vector table, hand sequences, then random traffic vs a bit-queue model.
module tb_user_wr_reg;

`ifdef USER_WR_LEN_CHK_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       DRCK = 1'b0;
    logic       RST  = 1'b1;
    logic       SEL = 1'b0, FSH = 1'b0, TDI = 1'b0;
    logic       CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0;
    logic       TDO, UPD_STRB, LEN_ERR;
    logic [7:0] PO;

    int n_tests = 0;
    int n_fail  = 0;

    user_wr_reg #(.WIDTH(8), .DEFAULT(8'hA5)) dut (
        .DRCK(DRCK), .RST(RST), .SEL(SEL), .FSH(FSH), .TDI(TDI),
        .CAPTURE(CAPTURE), .SHIFT(SHIFT), .UPDATE(UPDATE),
        .TDO(TDO), .PO(PO), .UPD_STRB(UPD_STRB), .LEN_ERR(LEN_ERR)
    );

    always #5 DRCK = ~DRCK;

    // Reference model: the shift register is a queue of bits, index 0 being the bit at TDO.
    bit         m_q[$];
    logic [7:0] m_po;
    bit         m_armed, m_err, m_strb;
    int         m_nshift;

    function automatic logic [7:0] pack_q();
        logic [7:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[i] = m_q[i];
        return w;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        for (int i = 0; i < 8; i++) m_q.push_back(1'b0);
        m_po = 8'hA5; m_armed = 0; m_err = 0; m_strb = 0; m_nshift = 0;
    endfunction

    function automatic void model_edge(bit sel, bit fsh, bit cap, bit shf, bit upd, bit tdi);
        bit s;
        s = 0;
        if (sel && fsh) begin
            if (cap) begin
                m_q.delete();
                for (int i = 0; i < 8; i++) m_q.push_back(m_po[i]);
                m_nshift = 0; m_err = 0; m_armed = 1;
            end else if (shf) begin
                m_q.push_back(tdi);
                void'(m_q.pop_front());
                m_nshift++;
            end else if (upd && m_armed) begin
                m_armed = 0;
                if (!EN || m_nshift == 8) begin
                    m_po = pack_q();
                    s = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
        m_strb = s;
    endfunction

    function automatic bit model_tdo();
        return SEL & FSH & m_q[0];
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit sel, input bit fsh, input bit cap, input bit shf, input bit upd, input bit tdi);
        SEL = sel; FSH = fsh; CAPTURE = cap; SHIFT = shf; UPDATE = upd; TDI = tdi;
        @(posedge DRCK);
        model_edge(sel, fsh, cap, shf, upd, tdi);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_po"},   PO,             m_po);
        chk({tag, "_strb"}, {7'd0, UPD_STRB}, {7'd0, m_strb});
        chk({tag, "_err"},  {7'd0, LEN_ERR},  {7'd0, m_err});
        chk({tag, "_tdo"},  {7'd0, TDO},      {7'd0, model_tdo()});
    endtask

    typedef struct {
        bit sel, fsh, cap, shf, upd, tdi;
        logic [7:0] po;
        bit strb, err, tdo;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit sel, bit fsh, bit cap, bit shf, bit upd, bit tdi,
                                logic [7:0] po, bit strb, bit err, bit tdo);
        vec_t v;
        v.sel = sel; v.fsh = fsh; v.cap = cap; v.shf = shf; v.upd = upd; v.tdi = tdi;
        v.po = po; v.strb = strb; v.err = err; v.tdo = tdo;
        tbl.push_back(v);
    endfunction

    initial begin
        model_reset();
        // Write 3C while A5 shifts back out LSB-first.
        add(1,1,1,0,0,0, 8'hA5,0,0,1);
        add(1,1,0,1,0,0, 8'hA5,0,0,0);
        add(1,1,0,1,0,0, 8'hA5,0,0,1);
        add(1,1,0,1,0,1, 8'hA5,0,0,0);
        add(1,1,0,1,0,1, 8'hA5,0,0,0);
        add(1,1,0,1,0,1, 8'hA5,0,0,1);
        add(1,1,0,1,0,1, 8'hA5,0,0,0);
        add(1,1,0,1,0,0, 8'hA5,0,0,1);
        add(1,1,0,1,0,0, 8'hA5,0,0,0);
        add(1,1,0,0,1,0, 8'h3C,1,0,0);
        add(1,1,0,0,0,0, 8'h3C,0,0,0);
        // Update with no capture is ignored.
        add(1,1,0,0,1,0, 8'h3C,0,0,0);
        // FSH low: the whole sequence is invisible.
        add(1,0,1,0,0,0, 8'h3C,0,0,0);
        add(1,0,0,1,0,1, 8'h3C,0,0,0);
        add(1,0,0,0,1,0, 8'h3C,0,0,0);
        add(1,1,0,0,1,0, 8'h3C,0,0,0);
        // Capture+shift+update together: only the capture lands (sr=3C, zero shifts).
        add(1,1,1,1,1,1, 8'h3C,0,0,0);
        add(1,1,0,0,1,0, 8'h3C,!EN,EN,0);
        add(1,1,0,0,0,0, 8'h3C,0,EN,0);

        repeat (2) @(posedge DRCK);
        @(negedge DRCK);
        RST = 1'b0;
        #1;
        chk("reset_po",   PO, 8'hA5);
        chk("reset_tdo",  {7'd0, TDO}, 8'h00);
        chk("reset_strb", {7'd0, UPD_STRB}, 8'h00);
        chk("reset_err",  {7'd0, LEN_ERR}, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].sel, tbl[i].fsh, tbl[i].cap, tbl[i].shf, tbl[i].upd, tbl[i].tdi);
            chk($sformatf("vec%0d_po", i),   PO, tbl[i].po);
            chk($sformatf("vec%0d_strb", i), {7'd0, UPD_STRB}, {7'd0, tbl[i].strb});
            chk($sformatf("vec%0d_err", i),  {7'd0, LEN_ERR},  {7'd0, tbl[i].err});
            chk($sformatf("vec%0d_tdo", i),  {7'd0, TDO},      {7'd0, tbl[i].tdo});
        end

        // Short shift of seven ones: sr becomes FE.
        step(1,1,1,0,0,0);
        for (int i = 0; i < 7; i++) step(1,1,0,1,0,1);
        step(1,1,0,0,1,0);
        chk("short_po",   PO, EN ? 8'h3C : 8'hFE);
        chk("short_err",  {7'd0, LEN_ERR}, {7'd0, EN});
        chk("short_strb", {7'd0, UPD_STRB}, {7'd0, !EN});
        step(1,1,1,0,0,0);
        chk("short_recap_err", {7'd0, LEN_ERR}, 8'h00);

        // Long shift (nine bits of 0x55 pattern) then update.
        for (int i = 0; i < 9; i++) step(1,1,0,1,0,i[0]);
        step(1,1,0,0,1,0);
        chk_model("long");

        // Asynchronous reset in the middle of a shift.
        step(1,1,1,0,0,0);
        for (int i = 0; i < 4; i++) step(1,1,0,1,0,1);
        RST = 1'b1;
        #2;
        model_reset();
        chk("midrst_po",   PO, 8'hA5);
        chk("midrst_tdo",  {7'd0, TDO}, 8'h00);
        chk("midrst_strb", {7'd0, UPD_STRB}, 8'h00);
        chk("midrst_err",  {7'd0, LEN_ERR}, 8'h00);
        #1;
        RST = 1'b0;
        step(1,1,0,0,1,0);
        chk("midrst_upd_po",   PO, 8'hA5);
        chk("midrst_upd_strb", {7'd0, UPD_STRB}, 8'h00);

        // Random traffic, biased toward complete capture/shift/update sequences.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 5) == 0, 1'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
